// File: rtl/sti_feeder_pkg.sv
// Shared types and constants for the serial-transmitter command feeder.
package sti_feeder_pkg;

  localparam int ENTRY_W = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_GAP,
    ST_END
  } state_e;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  // One queued command; packs to exactly ENTRY_W bits.
  typedef struct packed {
    logic        last;
    logic        low;
    logic        msb;
    logic        fill;
    logic [1:0]  length;
    logic [15:0] data;
  } cmd_entry_t;

  function automatic logic [5:0] len_bits(input logic [1:0] code);
    case (code)
      LEN_8:   return 6'd8;
      LEN_16:  return 6'd16;
      LEN_24:  return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/sti_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO with registered occupancy; head word is visible on rdata_o.
module sti_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sti_cmd_feeder.sv
// Buffers host commands and issues them one at a time to the serial transmitter.
// Defining STI_FEEDER_BITCHK_EN adds a per-burst bit-count check reported on sticky len_err.
module sti_cmd_feeder
  import sti_feeder_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int GAP_CYCLES    = 1,
  parameter int START_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic [1:0]  cmd_length,
  input  logic        cmd_fill,
  input  logic        cmd_msb,
  input  logic        cmd_low,
  input  logic        cmd_last,
  input  logic        so_valid,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic        busy,
  output logic        err
`ifdef STI_FEEDER_BITCHK_EN
  ,
  output logic        len_err
`endif
);

  // Handshake: a command transfers on every rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on registered state, so it never reacts to cmd_valid.

  localparam int            TW        = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [4:0]    GAP_LIMIT = 5'(GAP_CYCLES);

  state_e        state_q, state_d;
  cmd_entry_t    head, wentry, pi_q;
  logic          fifo_full, fifo_empty, push, in_issue;
  logic [TW-1:0] tmo_q;
  logic [3:0]    gap_q;
  logic          so_valid_q, err_q, last_acc_q;
  logic          so_fall, tmo_fire, gap_done;

  // Once a last-marked command is accepted nothing more is taken until reset.
  assign cmd_ready = !fifo_full && !last_acc_q && (state_q != ST_END);
  assign push      = cmd_valid && cmd_ready;
  assign wentry    = {cmd_last, cmd_low, cmd_msb, cmd_fill, cmd_length, cmd_data};

  sti_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (in_issue),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_issue = (state_q == ST_ISSUE);
  assign so_fall  = (state_q == ST_WAIT_DONE) && so_valid_q && !so_valid;
  assign tmo_fire = (state_q == ST_WAIT_START) && !so_valid && (tmo_q == TMO_LAST);
  // GAP always lasts at least one cycle; a zero gap still needs that cycle to leave.
  assign gap_done = ({1'b0, gap_q} + 5'd1) >= GAP_LIMIT;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (so_valid)      state_d = ST_WAIT_DONE;
        else if (tmo_fire) state_d = ST_GAP;
      end
      ST_WAIT_DONE:  if (so_fall) state_d = ST_GAP;
      ST_GAP:        if (gap_done) state_d = pi_q.last ? ST_END : ST_IDLE;
      ST_END:        state_d = ST_END;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pi_q       <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      so_valid_q <= 1'b0;
      err_q      <= 1'b0;
      last_acc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      so_valid_q <= so_valid;
      if (push && cmd_last) last_acc_q <= 1'b1;
      if (in_issue) pi_q <= head;
      if (in_issue) tmo_q <= '0;
      else if ((state_q == ST_WAIT_START) && !so_valid) tmo_q <= tmo_q + 1'b1;
      if (state_q != ST_GAP) gap_q <= '0;
      else if (!gap_done)    gap_q <= gap_q + 1'b1;
      if (tmo_fire) err_q <= 1'b1;
    end
  end

  // The head is shown during the load cycle so the transmitter samples it with load.
  assign load      = in_issue;
  assign pi_data   = in_issue ? head.data   : pi_q.data;
  assign pi_length = in_issue ? head.length : pi_q.length;
  assign pi_fill   = in_issue ? head.fill   : pi_q.fill;
  assign pi_msb    = in_issue ? head.msb    : pi_q.msb;
  assign pi_low    = in_issue ? head.low    : pi_q.low;
  assign pi_end    = (state_q == ST_END);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_END);
  assign err       = err_q;

`ifdef STI_FEEDER_BITCHK_EN
  logic [5:0] bits_q;
  logic       len_err_q;
  logic       in_burst;

  assign in_burst = (state_q == ST_WAIT_START) || (state_q == ST_WAIT_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (in_issue) bits_q <= '0;
      else if (in_burst && so_valid && (bits_q != 6'h3f)) bits_q <= bits_q + 1'b1;
      if (so_fall && (bits_q != len_bits(pi_q.length))) len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`endif

endmodule

// File: tb/tb_sti_cmd_feeder.sv
// Self-checking bench for sti_cmd_feeder: scoreboard of expected loads plus a transmitter model.
`timescale 1ns/1ps
module tb_sti_cmd_feeder;

  localparam int DEPTH         = 4;
  localparam int GAP_CYCLES    = 1;
  localparam int START_TIMEOUT = 8;
  localparam int GAP_EFF       = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_length;
  logic        cmd_fill, cmd_msb, cmd_low, cmd_last;
  logic        so_valid;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end, busy, err;
`ifdef STI_FEEDER_BITCHK_EN
  logic        len_err;
`endif

  sti_cmd_feeder #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_length(cmd_length), .cmd_fill(cmd_fill),
    .cmd_msb(cmd_msb), .cmd_low(cmd_low), .cmd_last(cmd_last), .so_valid(so_valid),
    .load(load), .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .busy(busy), .err(err)
`ifdef STI_FEEDER_BITCHK_EN
    , .len_err(len_err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [20:0] exp_q[$];       // {low, msb, fill, length, data} expected at each load
  int          plan_delay[$];  // transmitter start delay per accepted command (<=0: never starts)
  int          plan_len[$];    // so_valid high cycles per accepted command
  int          n_checks = 0;
  int          n_fail = 0;
  int          load_count = 0;
  int          last_load_cyc = 0;
  int          fall_cyc = 0;
  int          lat_exp = 0;
  bit          lat_armed = 0;
  bit          tx_abort = 0;
  logic [20:0] cur_pi = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bit count is 8 per length step.
  function automatic int ref_bits(input logic [1:0] code);
    return 8 * (int'(code) + 1);
  endfunction

  function automatic logic [21:0] rand_cmd(input logic last);
    return {last, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom)};
  endfunction

  // ---------------- driver tasks (enter/leave just after posedge) ----------------
  task automatic push_try(input logic [21:0] c, input int dly, input int nbits, output bit acc);
    cmd_valid = 1'b1;
    {cmd_last, cmd_low, cmd_msb, cmd_fill, cmd_length, cmd_data} = c;
    @(negedge clk);
    acc = cmd_ready;
    if (acc) begin
      exp_q.push_back(c[20:0]);
      plan_delay.push_back(dly);
      plan_len.push_back(nbits);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [21:0] c, input int dly, input int nbits);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 300) begin
      push_try(c, dly, nbits, acc);
      tries++;
    end
    if (!acc) check("push_wait_timeout", 32'(tries), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_load"}, load, 0);
    check({tag, "_pi"}, {pi_low, pi_msb, pi_fill, pi_length, pi_data}, 0);
    check({tag, "_pi_end"}, pi_end, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, cmd_ready, 1);
`ifdef STI_FEEDER_BITCHK_EN
    check({tag, "_len_err"}, len_err, 0);
`endif
  endtask

  // Assert reset between edges; optionally check outputs before any clock edge follows.
  task automatic do_reset(input bit chk_async, input string tag);
    @(negedge clk); #2;
    reset = 1'b0;
    tx_abort = 1'b1;
    cmd_valid = 1'b0;
    #1;
    if (chk_async) check_reset_vals(tag);
    repeat (5) @(posedge clk);
    exp_q.delete();
    plan_delay.delete();
    plan_len.delete();
    fall_cyc = 0;
    last_load_cyc = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    tx_abort = 1'b0;
  endtask

  task automatic wait_loads(input int target, input int budget);
    int n;
    n = 0;
    while (load_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (load_count < target) check("wait_loads_timeout", 32'(load_count), 32'(target));
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !busy && !so_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_pi_end(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!pi_end && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!pi_end) check("pi_end_timeout", pi_end, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- transmitter model ----------------
  initial begin : tx_model
    int d, n;
    so_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && load && plan_delay.size() > 0) begin
        d = plan_delay.pop_front();
        n = plan_len.pop_front();
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
          if (!tx_abort) begin
            so_valid = 1'b1;
            for (int i = 0; i < n; i++) begin
              @(posedge clk);
              if (tx_abort) break;
            end
            #1 so_valid = 1'b0;
            if (!tx_abort) fall_cyc = cyc;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic        prev_load, prev_err, prev_end;
    logic [20:0] e;
    prev_load = 0; prev_err = 0; prev_end = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (load) begin
          load_count++;
          check("load_one_cycle", prev_load, 0);
          if (fall_cyc > last_load_cyc) check("load_after_gap", 32'(cyc - fall_cyc >= GAP_EFF + 2), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_load", load, 0);
          end else begin
            e = exp_q.pop_front();
            check("load_fields", {pi_low, pi_msb, pi_fill, pi_length, pi_data}, e);
          end
          cur_pi = {pi_low, pi_msb, pi_fill, pi_length, pi_data};
          last_load_cyc = cyc;
          if (lat_armed) begin
            check("load_latency", 32'(cyc), 32'(lat_exp));
            lat_armed = 0;
          end
        end
        if (so_valid && !tx_abort) check("pi_hold", {pi_low, pi_msb, pi_fill, pi_length, pi_data}, cur_pi);
        if (err && !prev_err) check("err_timing", 32'(cyc), 32'(last_load_cyc + START_TIMEOUT + 1));
        if (pi_end && !prev_end) check("pi_end_timing", 32'(cyc), 32'(fall_cyc + GAP_EFF + 1));
      end
      prev_load = load;
      prev_err = err;
      prev_end = pi_end;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    bit          acc;
    int          base;
    logic [21:0] c;
    cmd_valid = 0; cmd_data = '0; cmd_length = '0;
    cmd_fill = 0; cmd_msb = 0; cmd_low = 0; cmd_last = 0;

    repeat (3) @(posedge clk); #1;
    check_reset_vals("rst_hold");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_release");

    // Single last-marked 16-bit command.
    base = load_count;
    push_try({1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 16'hA55A}, 2, 16, acc);
    check("a_accept", acc, 1);
    wait_pi_end(100);
    check("a_loads", 32'(load_count - base), 1);
    check("a_pi_data_held", pi_data, 16'hA55A);
    check("a_err", err, 0);
    check("a_ready_in_end", cmd_ready, 0);
    do_reset(0, "a");

    // Fill the FIFO behind a long burst; the fifth push must be refused.
    base = load_count;
    c = rand_cmd(1'b0);
    c[17:16] = 2'b11;
    lat_exp = cyc + 2;
    lat_armed = 1;
    push_try(c, 3, 32, acc);
    wait_loads(base + 1, 20);
    for (int i = 0; i < 5; i++) begin
      c = rand_cmd(1'b0);
      push_try(c, $urandom_range(1, 3), ref_bits(c[17:16]), acc);
      check("b_accept", acc, (i < DEPTH) ? 1 : 0);
    end
    wait_drain(800);
    check("b_loads", 32'(load_count - base), 5);

    // Start timeout: first command never answered, next one still issued.
    base = load_count;
    push_try(rand_cmd(1'b0), 0, 0, acc);
    c = rand_cmd(1'b0);
    push_try(c, 2, ref_bits(c[17:16]), acc);
    wait_drain(300);
    check("c_err", err, 1);
    check("c_loads", 32'(load_count - base), 2);
    do_reset(0, "c");
    check("c_err_cleared", err, 0);

    // Randomised traffic.
    base = load_count;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      c = rand_cmd(1'b0);
      push_wait(c, $urandom_range(1, 3), ref_bits(c[17:16]));
    end
    wait_drain(1500);
    check("r_loads", 32'(load_count - base), 12);

    // Reset during the second of three bursts.
    base = load_count;
    for (int i = 0; i < 3; i++) begin
      c = rand_cmd(1'b0);
      push_try(c, $urandom_range(1, 3), ref_bits(c[17:16]), acc);
    end
    wait_loads(base + 2, 300);
    repeat (4) @(posedge clk); #1;
    check("d_in_burst", so_valid, 1);
    do_reset(1, "d_async");
    repeat (30) @(posedge clk); #1;
    check("d_no_more_loads", 32'(load_count - base), 2);
    check("d_idle", busy, 0);

    // Last marker on the second of three pushes.
    base = load_count;
    c = rand_cmd(1'b0);
    push_try(c, 2, ref_bits(c[17:16]), acc);
    c = rand_cmd(1'b1);
    push_try(c, 1, ref_bits(c[17:16]), acc);
    push_try(rand_cmd(1'b0), 1, 8, acc);
    check("e_third_refused", acc, 0);
    wait_pi_end(300);
    repeat (20) @(posedge clk); #1;
    check("e_pi_end_held", pi_end, 1);
    check("e_loads", 32'(load_count - base), 2);
    check("e_not_busy", busy, 0);

`ifdef STI_FEEDER_BITCHK_EN
    do_reset(0, "f");
    push_try({1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h00C3}, 2, 9, acc);
    wait_drain(100);
    check("f_len_err_set", len_err, 1);
    do_reset(0, "g");
    push_try({1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h3C00}, 2, 8, acc);
    wait_drain(100);
    check("g_len_err_clear", len_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sti_cmd_feeder.md
Name: sti_cmd_feeder

Overview:
- Upstream stage of the serial transmitter / data-arrange top level.
- Accepts parallel transmit commands from a host over a valid/ready handshake and buffers them in a small FIFO.
- Issues each command to the transmitter as a one-cycle load with held pi_* fields, then waits for the serial burst to finish before issuing the next.
- After the last command drains, asserts pi_end so the downstream stage flushes and finishes.

Parameters:
- DEPTH, 4: command FIFO entries (power of two, >=2).
- GAP_CYCLES, 1: idle cycles between end of one burst and the next load (0..15).
- START_TIMEOUT, 8: cycles allowed from load to so_valid rising before err is flagged.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_data  in  16  word to transmit.
- cmd_length  in  2  00=8b, 01=16b, 10=24b, 11=32b.
- cmd_fill  in  1  fill mode for the transmitter.
- cmd_msb  in  1  MSB-first select.
- cmd_low  in  1  low-byte select (8b mode).
- cmd_last  in  1  marks final command of the job.
- so_valid  in  1  transmitter serial-valid, monitored.
- load  out  1  one-cycle load pulse.
- pi_data  out  16  held from load until next load.
- pi_length  out  2  held like pi_data.
- pi_fill  out  1  held like pi_data.
- pi_msb  out  1  held like pi_data.
- pi_low  out  1  held like pi_data.
- pi_end  out  1  end-of-job level.
- busy  out  1  state != IDLE and != END.
- err  out  1  sticky start-timeout flag.

Behaviour:
- Reset (reset low, async): FIFO empty, state IDLE. Outputs: load=0, pi_* = 0, pi_end=0, err=0, busy=0, cmd_ready=1.
- FIFO push when cmd_valid && cmd_ready. Each entry holds 22 bits {last, low, msb, fill, length, data}.
- cmd_ready = !full, registered-count based. A push and a pop in the same cycle at full are not allowed: ready is already low.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP, END.
  - IDLE: FIFO non-empty -> ISSUE.
  - ISSUE (1 cycle): pop the head; register its fields onto pi_*; load=1 in this cycle only; latch last into last_r; clear the timeout counter -> WAIT_START.
  - WAIT_START: so_valid=1 -> WAIT_DONE. If the counter reaches START_TIMEOUT, set err=1 (sticky) and go -> GAP, skipping the command.
  - WAIT_DONE: so_valid falls (registered so_valid_d=1, so_valid=0) -> GAP.
  - GAP: count GAP_CYCLES, with 0 meaning exit next cycle. Then -> END if last_r, else IDLE.
  - END: pi_end=1 held. cmd_ready=0. Stays until reset.
- Latency: push into an empty FIFO in IDLE -> load high 2 cycles later (IDLE sees non-empty, then ISSUE).
- pi_* change only in ISSUE. They are stable for the whole burst.
- so_valid high while in IDLE/GAP/END is ignored; no state change.
- If cmd_last arrives while earlier entries are still queued, those entries are issued first (in-order); END is entered only after the last-marked entry.
- Entries pushed after a last-marked entry are dropped, because cmd_ready goes low once a last-marked entry is accepted.
- Reset asserted mid-burst: everything returns to reset values immediately. Queued commands are lost.

Optional Feature:
- Macro STI_FEEDER_BITCHK_EN.
- Defined: count so_valid-high cycles in WAIT_START/WAIT_DONE. At the falling edge, compare against the expected length (8/16/24/32). A mismatch sets the sticky output len_err, which is reset to 0.
- Not defined: no counter, and no len_err port exists.

Decomposition:
- Package sti_feeder_pkg:
  - state enum;
  - length codes (LEN_8=2'b00 ... LEN_32=2'b11);
  - a function mapping length code to bit count (6-bit);
  - the FIFO entry width constant (22).
- One natural sub-module: sti_cmd_fifo, a synchronous DEPTH-entry FIFO with full/empty/count and async active-low reset.

Test Plan:
- Single command data=16'hA55A, length=01, last=1; model so_valid high 16 cycles starting 2 cycles after load -> exactly one load pulse, pi_data=A55A held through the burst, pi_end=1 GAP_CYCLES+1 cycles after so_valid falls, err=0.
- Push 5 commands back-to-back with DEPTH=4 -> cmd_ready low after 4 accepted. Loads are issued in push order, each only after the previous so_valid fall plus the gap.
- so_valid never rises after load -> err=1 exactly START_TIMEOUT cycles after WAIT_START entry; the next queued command is still issued.
- Drop reset low during WAIT_DONE of the second of 3 commands -> all outputs return to reset values asynchronously. After release, the FIFO is empty and there are no loads.
- cmd_last on the 2nd of 3 pushes -> third push refused (cmd_ready=0). pi_end rises after the 2nd burst and stays high; no third load.
- With STI_FEEDER_BITCHK_EN: length=00 with so_valid high 9 cycles -> len_err=1. A correct 8-cycle burst -> len_err stays 0.
